// File: rtl/prog_load_router.sv
// prog_load_router: fetches instruction words from the program loader one
// request at a time. It writes instruction words to IMEM and packs the
// payloads of HASH/ENCR/DECR into wide lines for the HASH/ENC/DEC BRAMs.
// cpu_start is raised after HALT. Any write past the end of a memory parks
// the block in ERR.
module prog_load_router #(
    parameter int WORD_W     = 16,
    parameter int OPC_W      = 5,
    parameter int LD_AW      = 16,
    parameter int ADDR_STEP  = 2,
    parameter int IMEM_AW    = 9,
    parameter int HASH_WORDS = 32,
    parameter int CIPH_WORDS = 8,
    parameter int HASH_AW    = 4,
    parameter int CIPH_AW    = 5,
    parameter logic [OPC_W-1:0] OPC_HASH = 5'h1C,
    parameter logic [OPC_W-1:0] OPC_ENCR = 5'h1D,
    parameter logic [OPC_W-1:0] OPC_DECR = 5'h1E,
    parameter logic [OPC_W-1:0] OPC_HALT = 5'h1F
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    output logic                         ld_req,
    output logic [LD_AW-1:0]             ld_addr,
    input  logic                         ld_valid,
    input  logic [WORD_W-1:0]            ld_data,
    output logic                         imem_we,
    output logic [IMEM_AW-1:0]           imem_addr,
    output logic [WORD_W-1:0]            imem_wdata,
    output logic                         hash_we,
    output logic [HASH_AW-1:0]           hash_addr,
    output logic [HASH_WORDS*WORD_W-1:0] hash_wdata,
    output logic                         enc_we,
    output logic [CIPH_AW-1:0]           enc_addr,
    output logic [CIPH_WORDS*WORD_W-1:0] enc_wdata,
    output logic                         dec_we,
    output logic [CIPH_AW-1:0]           dec_addr,
    output logic [CIPH_WORDS*WORD_W-1:0] dec_wdata,
    output logic                         cpu_start,
    output logic                         busy,
    output logic                         err
);
    localparam int HASH_BW   = HASH_WORDS * WORD_W;
    localparam int CIPH_BW   = CIPH_WORDS * WORD_W;
    localparam int MAX_WORDS = (HASH_WORDS > CIPH_WORDS) ? HASH_WORDS : CIPH_WORDS;
    localparam int REM_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HALTED, S_ERR} state_t;
    typedef enum logic [1:0] {CH_HASH, CH_ENC, CH_DEC} chan_t;

    // Counters carry one extra bit: the MSB set means the memory is full.
    state_t               state_q, state_d;
    logic [LD_AW-1:0]     ld_addr_q, ld_addr_d;
    logic [IMEM_AW:0]     imem_cnt_q, imem_cnt_d;
    logic [HASH_AW:0]     hash_cnt_q, hash_cnt_d;
    logic [CIPH_AW:0]     enc_cnt_q, enc_cnt_d;
    logic [CIPH_AW:0]     dec_cnt_q, dec_cnt_d;
    logic                 payload_q, payload_d;
    chan_t                chan_q, chan_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [HASH_BW-1:0]   hash_buf_q, hash_buf_d;
    logic [CIPH_BW-1:0]   ciph_buf_q, ciph_buf_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 hash_we_q, hash_we_d;
    logic [HASH_AW-1:0]   hash_addr_q, hash_addr_d;
    logic                 enc_we_q, enc_we_d;
    logic [CIPH_AW-1:0]   enc_addr_q, enc_addr_d;
    logic                 dec_we_q, dec_we_d;
    logic [CIPH_AW-1:0]   dec_addr_q, dec_addr_d;

    logic [OPC_W-1:0]     opc;
    assign opc = ld_data[WORD_W-1 -: OPC_W];

    // Next-state logic: request/wait handshake, IMEM writes, payload packing.
    always_comb begin
        state_d      = state_q;
        ld_addr_d    = ld_addr_q;
        imem_cnt_d   = imem_cnt_q;
        hash_cnt_d   = hash_cnt_q;
        enc_cnt_d    = enc_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        payload_d    = payload_q;
        chan_d       = chan_q;
        rem_d        = rem_q;
        // A line is presented for exactly one strobe cycle, then the buffer empties.
        hash_buf_d   = hash_we_q ? '0 : hash_buf_q;
        ciph_buf_d   = (enc_we_q || dec_we_q) ? '0 : ciph_buf_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        hash_we_d    = 1'b0;
        hash_addr_d  = hash_addr_q;
        enc_we_d     = 1'b0;
        enc_addr_d   = enc_addr_q;
        dec_we_d     = 1'b0;
        dec_addr_d   = dec_addr_q;

        case (state_q)
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (ld_valid) begin
                    ld_addr_d = ld_addr_q + LD_AW'(ADDR_STEP);
                    state_d   = S_REQ;
                    if (payload_q) begin
                        // Payload words are shifted in unchecked; the first lands in the MSBs.
                        if (chan_q == CH_HASH)
                            hash_buf_d = {hash_buf_q[HASH_BW-WORD_W-1:0], ld_data};
                        else
                            ciph_buf_d = {ciph_buf_q[CIPH_BW-WORD_W-1:0], ld_data};
                        if (rem_q == REM_W'(1)) begin
                            payload_d = 1'b0;
                            case (chan_q)
                                CH_HASH: begin
                                    if (hash_cnt_q[HASH_AW]) state_d = S_ERR;
                                    else begin
                                        hash_we_d   = 1'b1;
                                        hash_addr_d = hash_cnt_q[HASH_AW-1:0];
                                        hash_cnt_d  = hash_cnt_q + (HASH_AW+1)'(1);
                                    end
                                end
                                CH_ENC: begin
                                    if (enc_cnt_q[CIPH_AW]) state_d = S_ERR;
                                    else begin
                                        enc_we_d   = 1'b1;
                                        enc_addr_d = enc_cnt_q[CIPH_AW-1:0];
                                        enc_cnt_d  = enc_cnt_q + (CIPH_AW+1)'(1);
                                    end
                                end
                                default: begin
                                    if (dec_cnt_q[CIPH_AW]) state_d = S_ERR;
                                    else begin
                                        dec_we_d   = 1'b1;
                                        dec_addr_d = dec_cnt_q[CIPH_AW-1:0];
                                        dec_cnt_d  = dec_cnt_q + (CIPH_AW+1)'(1);
                                    end
                                end
                            endcase
                        end else begin
                            rem_d = rem_q - REM_W'(1);
                        end
                    end else if (imem_cnt_q[IMEM_AW]) begin
                        state_d = S_ERR;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = imem_cnt_q[IMEM_AW-1:0];
                        imem_wdata_d = ld_data;
                        imem_cnt_d   = imem_cnt_q + (IMEM_AW+1)'(1);
                        if (opc == OPC_HALT) begin
                            state_d = S_HALTED;
                        end else if (opc == OPC_HASH) begin
                            payload_d = 1'b1;
                            chan_d    = CH_HASH;
                            rem_d     = REM_W'(HASH_WORDS);
                        end else if (opc == OPC_ENCR || opc == OPC_DECR) begin
                            payload_d = 1'b1;
                            chan_d    = (opc == OPC_ENCR) ? CH_ENC : CH_DEC;
                            rem_d     = REM_W'(CIPH_WORDS);
                        end
                    end
                end
            end
            default: begin
                // IDLE, HALTED and ERR all restart the load from scratch on go.
                if (go) begin
                    state_d    = S_REQ;
                    ld_addr_d  = '0;
                    imem_cnt_d = '0;
                    hash_cnt_d = '0;
                    enc_cnt_d  = '0;
                    dec_cnt_d  = '0;
                    payload_d  = 1'b0;
                    rem_d      = '0;
                    hash_buf_d = '0;
                    ciph_buf_d = '0;
                end
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ld_addr_q    <= '0;
            imem_cnt_q   <= '0;
            hash_cnt_q   <= '0;
            enc_cnt_q    <= '0;
            dec_cnt_q    <= '0;
            payload_q    <= 1'b0;
            chan_q       <= CH_HASH;
            rem_q        <= '0;
            hash_buf_q   <= '0;
            ciph_buf_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            hash_we_q    <= 1'b0;
            hash_addr_q  <= '0;
            enc_we_q     <= 1'b0;
            enc_addr_q   <= '0;
            dec_we_q     <= 1'b0;
            dec_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ld_addr_q    <= ld_addr_d;
            imem_cnt_q   <= imem_cnt_d;
            hash_cnt_q   <= hash_cnt_d;
            enc_cnt_q    <= enc_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            payload_q    <= payload_d;
            chan_q       <= chan_d;
            rem_q        <= rem_d;
            hash_buf_q   <= hash_buf_d;
            ciph_buf_q   <= ciph_buf_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            hash_we_q    <= hash_we_d;
            hash_addr_q  <= hash_addr_d;
            enc_we_q     <= enc_we_d;
            enc_addr_q   <= enc_addr_d;
            dec_we_q     <= dec_we_d;
            dec_addr_q   <= dec_addr_d;
        end
    end

    // Block data is only meaningful while the matching strobe is high.
    assign ld_req     = (state_q == S_REQ);
    assign ld_addr    = ld_addr_q;
    assign busy       = (state_q == S_REQ) || (state_q == S_WAIT);
    assign cpu_start  = (state_q == S_HALTED);
    assign err        = (state_q == S_ERR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign hash_we    = hash_we_q;
    assign hash_addr  = hash_addr_q;
    assign hash_wdata = hash_buf_q;
    assign enc_we     = enc_we_q;
    assign enc_addr   = enc_addr_q;
    assign enc_wdata  = ciph_buf_q;
    assign dec_we     = dec_we_q;
    assign dec_addr   = dec_addr_q;
    assign dec_wdata  = ciph_buf_q;

endmodule

// File: tb/tb_prog_load_router.sv
// Testbench for prog_load_router. A table of loader words with the expected
// reaction one cycle after each word is accepted. A second instance with a
// 4-entry IMEM exercises overflow.
module tb_prog_load_router;
    logic clk, rst_n, go0, go1, ld_valid;
    logic [15:0] ld_data;

    logic ld_req, imem_we, hash_we, enc_we, dec_we, cpu_start, busy, err;
    logic [15:0] ld_addr, imem_wdata;
    logic [8:0] imem_addr;
    logic [3:0] hash_addr;
    logic [4:0] enc_addr, dec_addr;
    logic [511:0] hash_wdata;
    logic [127:0] enc_wdata, dec_wdata;

    logic s_ld_req, s_imem_we, s_hash_we, s_enc_we, s_dec_we, s_cpu_start, s_busy, s_err;
    logic [15:0] s_ld_addr, s_imem_wdata;
    logic [1:0] s_imem_addr;
    logic [3:0] s_hash_addr;
    logic [4:0] s_enc_addr, s_dec_addr;
    logic [511:0] s_hash_wdata;
    logic [127:0] s_enc_wdata, s_dec_wdata;

    prog_load_router dut (
        .clk(clk), .rst_n(rst_n), .go(go0), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_valid(ld_valid), .ld_data(ld_data), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .hash_we(hash_we), .hash_addr(hash_addr),
        .hash_wdata(hash_wdata), .enc_we(enc_we), .enc_addr(enc_addr), .enc_wdata(enc_wdata),
        .dec_we(dec_we), .dec_addr(dec_addr), .dec_wdata(dec_wdata),
        .cpu_start(cpu_start), .busy(busy), .err(err));

    prog_load_router #(.IMEM_AW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .go(go1), .ld_req(s_ld_req), .ld_addr(s_ld_addr),
        .ld_valid(ld_valid), .ld_data(ld_data), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .hash_we(s_hash_we), .hash_addr(s_hash_addr),
        .hash_wdata(s_hash_wdata), .enc_we(s_enc_we), .enc_addr(s_enc_addr),
        .enc_wdata(s_enc_wdata), .dec_we(s_dec_we), .dec_addr(s_dec_addr),
        .dec_wdata(s_dec_wdata), .cpu_start(s_cpu_start), .busy(s_busy), .err(s_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed view: sel=0 main instance, sel=1 small instance.
    logic sel;
    logic m_ld_req, m_imem_we, m_cpu_start, m_busy, m_err;
    logic [2:0] m_blk_we;
    logic [15:0] m_ld_addr, m_imem_wdata;
    logic [8:0] m_imem_addr;
    assign m_ld_req     = sel ? s_ld_req : ld_req;
    assign m_imem_we    = sel ? s_imem_we : imem_we;
    assign m_cpu_start  = sel ? s_cpu_start : cpu_start;
    assign m_busy       = sel ? s_busy : busy;
    assign m_err        = sel ? s_err : err;
    assign m_blk_we     = sel ? {s_hash_we, s_enc_we, s_dec_we} : {hash_we, enc_we, dec_we};
    assign m_ld_addr    = sel ? s_ld_addr : ld_addr;
    assign m_imem_wdata = sel ? s_imem_wdata : imem_wdata;
    assign m_imem_addr  = sel ? {7'd0, s_imem_addr} : imem_addr;

    // ch: 0 instruction, 1 hash payload, 2 enc payload, 3 dec payload.
    typedef struct {
        logic [15:0] data;
        int lat;
        bit spur;
        int iwe;
        int iaddr;
        int ch;
        int bwe;
        int baddr;
        int halt;
        int err;
    } vec_t;

    vec_t vecs[$];
    int n_vec, n_bad, exp_addr;
    logic [511:0] acc_h;
    logic [127:0] acc_c;

    task automatic add(input logic [15:0] d, input int lat, input bit spur, input int iwe,
                       input int iaddr, input int ch, input int bwe, input int baddr,
                       input int halt, input int e);
        vec_t v;
        v.data = d; v.lat = lat; v.spur = spur; v.iwe = iwe; v.iaddr = iaddr;
        v.ch = ch; v.bwe = bwe; v.baddr = baddr; v.halt = halt; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(input string nm);
        chk({nm, "_ctl"}, 32'({ld_req, busy, cpu_start, err, imem_we, hash_we, enc_we, dec_we}), 32'd0);
        chk({nm, "_addr"}, 32'({ld_addr, imem_addr, hash_addr}), 32'd0);
        chk({nm, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        chk({nm, "_caddr"}, 32'({enc_addr, dec_addr}), 32'd0);
        chkw({nm, "_hash_wdata"}, hash_wdata, 512'd0);
        chkw({nm, "_ciph_wdata"}, 512'({enc_wdata, dec_wdata}), 512'd0);
        chk({nm, "_small"}, 32'({s_ld_req, s_busy, s_cpu_start, s_err, s_imem_we, s_hash_we,
                                 s_enc_we, s_dec_we, |s_ld_addr, |s_imem_addr, |s_imem_wdata,
                                 |s_hash_addr, |s_enc_addr, |s_dec_addr, |s_hash_wdata,
                                 |s_enc_wdata, |s_dec_wdata}), 32'd0);
    endtask

    // Act as the loader for one word, then check the reaction at t+1.
    task automatic serve(input vec_t v);
        int guard;
        int wait_n;
        int exp_blk;
        guard = 0;
        while (!m_ld_req && guard < 50) begin
            tick();
            guard++;
        end
        if (!m_ld_req) begin
            chk("ld_req_timeout", 32'(m_ld_req), 32'd1);
            return;
        end
        chk("ld_addr", 32'(m_ld_addr), 32'(exp_addr));
        wait_n = v.lat;
        if (v.spur) begin
            ld_valid = 1'b1;
            ld_data  = 16'hF800;
            tick();
            ld_valid = 1'b0;
            wait_n   = v.lat - 1;
        end
        repeat (wait_n) tick();
        ld_valid = 1'b1;
        ld_data  = v.data;
        tick();
        ld_valid = 1'b0;
        exp_addr += 2;
        if (v.ch == 1) acc_h = {acc_h[495:0], v.data};
        if (v.ch >= 2) acc_c = {acc_c[111:0], v.data};

        chk("imem_we", 32'(m_imem_we), 32'(v.iwe));
        if (v.iwe != 0) begin
            chk("imem_addr", 32'(m_imem_addr), 32'(v.iaddr));
            chk("imem_wdata", 32'(m_imem_wdata), 32'(v.data));
        end
        exp_blk = (v.bwe == 0) ? 0 : (v.ch == 1) ? 4 : (v.ch == 2) ? 2 : 1;
        chk("blk_we", 32'(m_blk_we), 32'(exp_blk));
        if (v.bwe != 0 && v.ch == 1) begin
            chk("hash_addr", 32'(hash_addr), 32'(v.baddr));
            chkw("hash_wdata", hash_wdata, acc_h);
            acc_h = '0;
        end
        if (v.bwe != 0 && v.ch == 2) begin
            chk("enc_addr", 32'(enc_addr), 32'(v.baddr));
            chkw("enc_wdata", 512'(enc_wdata), 512'(acc_c));
            acc_c = '0;
        end
        if (v.bwe != 0 && v.ch == 3) begin
            chk("dec_addr", 32'(dec_addr), 32'(v.baddr));
            chkw("dec_wdata", 512'(dec_wdata), 512'(acc_c));
            acc_c = '0;
        end
        chk("cpu_start", 32'(m_cpu_start), 32'(v.halt));
        chk("err", 32'(m_err), 32'(v.err));
        chk("ld_req_next", 32'(m_ld_req), (v.halt != 0 || v.err != 0) ? 32'd0 : 32'd1);
        chk("busy", 32'(m_busy), (v.halt != 0 || v.err != 0) ? 32'd0 : 32'd1);
    endtask

    task automatic run(input bit which, input int first, input int last_i);
        sel = which;
        if (which) go1 = 1'b1; else go0 = 1'b1;
        tick();
        go0 = 1'b0;
        go1 = 1'b0;
        exp_addr = 0;
        acc_h = '0;
        acc_c = '0;
        chk("start_flags", 32'({m_cpu_start, m_err, m_busy}), 32'b001);
        for (int i = first; i <= last_i; i++) serve(vecs[i]);
    endtask

    // Idle window with stray ld_valid pulses: nothing may move.
    task automatic quiet(input int n, input bit halted);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = i[0];
            ld_data  = 16'h0800;
            tick();
            if (m_ld_req || m_imem_we || (m_blk_we != 3'b000) || m_busy ||
                (m_cpu_start != halted) || (m_err != !halted))
                bad = 1'b1;
        end
        ld_valid = 1'b0;
        chk("quiet", 32'(bad), 32'd0);
    endtask

    int a0, b0, c0, d0, e0, f0, g0, g1;

    initial begin
        n_vec = 0; n_bad = 0; sel = 1'b0; go0 = 1'b0; go1 = 1'b0;
        ld_valid = 1'b0; ld_data = '0; rst_n = 1'b1; exp_addr = 0;
        acc_h = '0; acc_c = '0;

        //   data     lat spur iwe iaddr ch bwe baddr halt err
        a0 = vecs.size();
        add(16'h0800, 2, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        add(16'h1000, 2, 1'b0, 1, 1, 0, 0, 0, 0, 0);
        add(16'hF800, 2, 1'b0, 1, 2, 0, 0, 0, 1, 0);
        b0 = vecs.size();
        add(16'hE000, 1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++)
            add(16'(k), (k == 5) ? 7 : 1, k == 5, 0, 0, 1, (k == 31) ? 1 : 0, 0, 0, 0);
        add(16'hF800, 1, 1'b0, 1, 1, 0, 0, 0, 1, 0);
        c0 = vecs.size();
        add(16'hE800, 1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add((k == 2) ? 16'hF800 : 16'(16'h1100 + k), (k == 3) ? 7 : 1, k == 3,
                0, 0, 2, (k == 7) ? 1 : 0, 0, 0, 0);
        add(16'hF000, 2, 1'b1, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(16'(16'h2200 + k), 1, 1'b0, 0, 0, 3, (k == 7) ? 1 : 0, 0, 0, 0);
        add(16'hE800, 7, 1'b1, 1, 2, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(16'(16'h3300 + k), 1, 1'b0, 0, 0, 2, (k == 7) ? 1 : 0, 1, 0, 0);
        add(16'hF800, 1, 1'b0, 1, 3, 0, 0, 0, 1, 0);
        d0 = vecs.size();
        for (int k = 0; k < 4; k++)
            add(16'(k + 1), 1, 1'b0, 1, k, 0, 0, 0, 0, 0);
        add(16'h0005, 1, 1'b0, 0, 0, 0, 0, 0, 0, 1);
        e0 = vecs.size();
        add(16'h0007, 1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        add(16'hF800, 1, 1'b0, 1, 1, 0, 0, 0, 1, 0);
        f0 = vecs.size();
        add(16'hE800, 1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        add(16'hAAAA, 1, 1'b0, 0, 0, 2, 0, 0, 0, 0);
        add(16'hBBBB, 1, 1'b0, 0, 0, 2, 0, 0, 0, 0);
        add(16'hCCCC, 1, 1'b0, 0, 0, 2, 0, 0, 0, 0);
        g0 = vecs.size();
        add(16'hE800, 1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(16'(16'h0101 * (k + 1)), 1, 1'b0, 0, 0, 2, (k == 7) ? 1 : 0, 0, 0, 0);
        add(16'hF800, 1, 1'b0, 1, 1, 0, 0, 0, 1, 0);
        g1 = vecs.size();

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_checks("reset");
        rst_n = 1'b1;
        tick();

        run(1'b0, a0, b0 - 1);
        quiet(8, 1'b1);
        run(1'b0, b0, c0 - 1);
        quiet(3, 1'b1);
        run(1'b0, c0, d0 - 1);
        quiet(3, 1'b1);
        run(1'b1, d0, e0 - 1);
        quiet(5, 1'b0);
        run(1'b1, e0, f0 - 1);
        quiet(3, 1'b1);

        // Abort an ENCR block part-way with an asynchronous reset.
        run(1'b0, f0, g0 - 1);
        #2 rst_n = 1'b0;
        #1;
        rst_checks("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run(1'b0, g0, g1 - 1);
        quiet(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
